// File: rtl/regfile_2w2r.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2w2r
//  Description : Parametrised register file, NREGS x WIDTH, two write ports,
//                two registered read ports with write-first forwarding, a
//                read-hold enable and an independent status register S.
//                R0 is hard-wired to zero.
//  Ports       : clk        rising-edge clock
//                Reset      asynchronous active-high reset, clears all state
//                Ra, Rb     read addresses (ports A/B)
//                RE         1 = load A/B on this edge, 0 = hold A/B
//                Rd0/D0/WE0 write port 0 (address, data, enable)
//                Rd1/D1/WE1 write port 1 (address, data, enable); wins on
//                           a same-address collision with port 0
//                SD, SE     status write data / enable
//                A, B       registered read data
//                S          status register
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2w2r #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS),
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  input  logic             RE,
  input  logic [AW-1:0]    Rd0,
  input  logic [WIDTH-1:0] D0,
  input  logic             WE0,
  input  logic [AW-1:0]    Rd1,
  input  logic [WIDTH-1:0] D1,
  input  logic             WE1,
  input  logic [SW-1:0]    SD,
  input  logic             SE,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [SW-1:0]    S
);

  // R0 has no storage; only R1..R(NREGS-1) exist.
  logic [WIDTH-1:0] store [1:NREGS-1];

  // Post-write value of the addressed registers, used to load A/B.
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (Ra == AW'(i)) rd_a = store[i];
      if (Rb == AW'(i)) rd_b = store[i];
    end
    // Write-first forwarding: a same-edge write to the read address is
    // returned directly, port 1 taking precedence as it does in storage.
    if (Ra != '0) begin
      if (WE1 && (Rd1 == Ra))      rd_a = D1;
      else if (WE0 && (Rd0 == Ra)) rd_a = D0;
    end
    if (Rb != '0) begin
      if (WE1 && (Rd1 == Rb))      rd_b = D1;
      else if (WE0 && (Rd0 == Rb)) rd_b = D0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 1; i < NREGS; i++) begin
        store[i] <= '0;
      end
      A <= '0;
      B <= '0;
      S <= '0;
    end else begin
      // Port 1 is checked first so a collision on one address keeps D1.
      for (int i = 1; i < NREGS; i++) begin
        if (WE1 && (Rd1 == AW'(i)))      store[i] <= D1;
        else if (WE0 && (Rd0 == AW'(i))) store[i] <= D0;
      end
      if (RE) begin
        A <= rd_a;
        B <= rd_b;
      end
      if (SE) begin
        S <= SD;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_2w2r.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_2w2r
//  Description : Self-checking bench for regfile_2w2r. Drives a 16x16 and a
//                32x32 instance and compares against an array-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2w2r;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  // 16 x 16 instance
  logic [3:0]  ra, rb, rd0, rd1;
  logic        re, we0, we1, se;
  logic [15:0] d0, d1, a, b;
  logic [3:0]  sd, s;

  // 32 x 32 instance
  logic [4:0]  ra2, rb2, rd0_2, rd1_2;
  logic        re2, we0_2, we1_2, se2;
  logic [31:0] d0_2, d1_2, a2, b2;
  logic [3:0]  sd2, s2;

  regfile_2w2r #(.WIDTH(16), .NREGS(16)) dut (
    .clk(clk), .Reset(Reset), .Ra(ra), .Rb(rb), .RE(re),
    .Rd0(rd0), .D0(d0), .WE0(we0), .Rd1(rd1), .D1(d1), .WE1(we1),
    .SD(sd), .SE(se), .A(a), .B(b), .S(s)
  );

  regfile_2w2r #(.WIDTH(32), .NREGS(32)) dut2 (
    .clk(clk), .Reset(Reset), .Ra(ra2), .Rb(rb2), .RE(re2),
    .Rd0(rd0_2), .D0(d0_2), .WE0(we0_2), .Rd1(rd1_2), .D1(d1_2), .WE1(we1_2),
    .SD(sd2), .SE(se2), .A(a2), .B(b2), .S(s2)
  );

  // Reference model: plain arrays, writes applied in port order then read.
  logic [15:0] m  [0:15];
  logic [31:0] m2 [0:31];
  logic [15:0] ea, eb;
  logic [31:0] ea2, eb2;
  logic [3:0]  es, es2;

  int errors = 0;
  int checks = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int i = 0; i < 32; i++) m2[i] = '0;
    ea = '0; eb = '0; es = '0;
    ea2 = '0; eb2 = '0; es2 = '0;
  endtask

  task automatic idle();
    ra = 0; rb = 0; rd0 = 0; rd1 = 0; re = 0; we0 = 0; we1 = 0; se = 0;
    d0 = 0; d1 = 0; sd = 0;
    ra2 = 0; rb2 = 0; rd0_2 = 0; rd1_2 = 0; re2 = 0; we0_2 = 0; we1_2 = 0;
    se2 = 0; d0_2 = 0; d1_2 = 0; sd2 = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs present at
  // that edge; returns 1 time unit after the edge.
  task automatic tick();
    if (!Reset) begin
      if (we0 && rd0 != 0) m[rd0] = d0;
      if (we1 && rd1 != 0) m[rd1] = d1;
      if (re) begin ea = m[ra]; eb = m[rb]; end
      if (se) es = sd;
      if (we0_2 && rd0_2 != 0) m2[rd0_2] = d0_2;
      if (we1_2 && rd1_2 != 0) m2[rd1_2] = d1_2;
      if (re2) begin ea2 = m2[ra2]; eb2 = m2[rb2]; end
      if (se2) es2 = sd2;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    #1;
    checks++;
    if (a !== 16'h0 || b !== 16'h0 || s !== 4'h0) begin
      errors++;
      $display("FAIL reset_initial: got A=%h B=%h S=%h required 0/0/0", a, b, s);
    end
    checks++;
    if (a2 !== 32'h0 || b2 !== 32'h0 || s2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_initial_32: got A=%h B=%h S=%h required 0/0/0", a2, b2, s2);
    end
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1;
    we0 = 1; rd0 = 5; d0 = 16'h1234;
    tick();
    re = 1; ra = 5; rb = 5; se = 1; sd = 4'hF;
    tick();
    checks++;
    if (a !== 16'h1234 || s !== 4'hF) begin
      errors++;
      $display("FAIL reset_preload: got A=%h S=%h required 1234/f", a, s);
    end
    // Assert reset mid-cycle: outputs must clear with no clock edge.
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (a !== 16'h0 || b !== 16'h0 || s !== 4'h0) begin
      errors++;
      $display("FAIL reset_async: got A=%h B=%h S=%h required 0/0/0", a, b, s);
    end
    model_clear();
    // Enables during reset must be ignored.
    we0 = 1; rd0 = 5; d0 = 16'hFFFF; re = 1; ra = 5; se = 1; sd = 4'h3;
    tick();
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk); #1;
    re = 1; ra = 5; rb = 5;
    tick();
    checks++;
    if (a !== 16'h0 || b !== 16'h0 || s !== 4'h0) begin
      errors++;
      $display("FAIL reset_cleared_r5: got A=%h B=%h S=%h required 0/0/0", a, b, s);
    end
  endtask

  task automatic test_basic();
    we0 = 1; rd0 = 3; d0 = 16'hBEEF;
    tick();
    re = 1; ra = 3; rb = 0;
    tick();
    checks++;
    if (a !== 16'hBEEF || b !== 16'h0000) begin
      errors++;
      $display("FAIL basic_rw: got A=%h B=%h required beef/0000", a, b);
    end
    we1 = 1; rd1 = 0; d1 = 16'hFFFF;
    tick();
    re = 1; ra = 0; rb = 0;
    tick();
    checks++;
    if (a !== 16'h0000 || b !== 16'h0000) begin
      errors++;
      $display("FAIL basic_r0: got A=%h B=%h required 0000/0000", a, b);
    end
  endtask

  task automatic test_forward();
    we1 = 1; rd1 = 7; d1 = 16'hA5A5; re = 1; ra = 7; rb = 7;
    tick();
    checks++;
    if (a !== 16'hA5A5 || b !== 16'hA5A5) begin
      errors++;
      $display("FAIL forward: got A=%h B=%h required a5a5/a5a5", a, b);
    end
  endtask

  task automatic test_collision();
    we0 = 1; we1 = 1; rd0 = 9; rd1 = 9; d0 = 16'h1111; d1 = 16'h2222;
    re = 1; ra = 9; rb = 9;
    tick();
    checks++;
    if (a !== 16'h2222 || b !== 16'h2222) begin
      errors++;
      $display("FAIL collision_fwd: got A=%h B=%h required 2222/2222", a, b);
    end
    re = 1; ra = 9; rb = 1;
    tick();
    checks++;
    if (a !== 16'h2222) begin
      errors++;
      $display("FAIL collision_stored: got A=%h required 2222", a);
    end
    we0 = 1; we1 = 1; rd0 = 2; rd1 = 4; d0 = 16'h0C0C; d1 = 16'h4D4D;
    tick();
    re = 1; ra = 2; rb = 4;
    tick();
    checks++;
    if (a !== 16'h0C0C || b !== 16'h4D4D) begin
      errors++;
      $display("FAIL dual_write: got A=%h B=%h required 0c0c/4d4d", a, b);
    end
  endtask

  task automatic test_hold();
    re = 1; ra = 3;
    tick();
    re = 0; ra = 1; we0 = 1; rd0 = 3; d0 = 16'h0001;
    tick();
    checks++;
    if (a !== 16'hBEEF) begin
      errors++;
      $display("FAIL hold: got A=%h required beef", a);
    end
    re = 1; ra = 3;
    tick();
    checks++;
    if (a !== 16'h0001) begin
      errors++;
      $display("FAIL hold_release: got A=%h required 0001", a);
    end
  endtask

  task automatic test_status();
    se = 1; sd = 4'b1010;
    tick();
    checks++;
    if (s !== 4'b1010) begin
      errors++;
      $display("FAIL status_write: got S=%b required 1010", s);
    end
    se = 0; sd = 4'b0101; we0 = 1; rd0 = 6; d0 = 16'h5555;
    tick();
    checks++;
    if (s !== 4'b1010) begin
      errors++;
      $display("FAIL status_hold: got S=%b required 1010", s);
    end
  endtask

  task automatic test_params();
    we0_2 = 1; rd0_2 = 31; d0_2 = 32'hDEADBEEF;
    tick();
    re2 = 1; ra2 = 31; rb2 = 0;
    tick();
    checks++;
    if (a2 !== 32'hDEADBEEF || b2 !== 32'h0) begin
      errors++;
      $display("FAIL wide_rw: got A=%h B=%h required deadbeef/00000000", a2, b2);
    end
    we1_2 = 1; rd1_2 = 0; d1_2 = 32'hFFFFFFFF;
    tick();
    re2 = 1; ra2 = 0; rb2 = 31;
    tick();
    checks++;
    if (a2 !== 32'h0 || b2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wide_r0: got A=%h B=%h required 00000000/deadbeef", a2, b2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      // Narrow address range half the time to provoke collisions/forwarding.
      if ($urandom_range(0, 1) == 1) begin
        rd0 = 4'($urandom_range(0, 3)); rd1 = 4'($urandom_range(0, 3));
        ra = 4'($urandom_range(0, 3));  rb = 4'($urandom_range(0, 3));
        rd0_2 = 5'($urandom_range(0, 3)); rd1_2 = 5'($urandom_range(0, 3));
        ra2 = 5'($urandom_range(0, 3));   rb2 = 5'($urandom_range(0, 3));
      end else begin
        rd0 = 4'($urandom); rd1 = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
        rd0_2 = 5'($urandom); rd1_2 = 5'($urandom);
        ra2 = 5'($urandom); rb2 = 5'($urandom);
      end
      we0 = 1'($urandom); we1 = 1'($urandom); re = 1'($urandom); se = 1'($urandom);
      d0 = 16'($urandom); d1 = 16'($urandom); sd = 4'($urandom);
      we0_2 = 1'($urandom); we1_2 = 1'($urandom); re2 = 1'($urandom); se2 = 1'($urandom);
      d0_2 = $urandom; d1_2 = $urandom; sd2 = 4'($urandom);
      tick();
      checks++;
      if (a !== ea || b !== eb || s !== es) begin
        errors++;
        $display("FAIL random16 cyc %0d: got A=%h B=%h S=%h required %h/%h/%h",
                 n, a, b, s, ea, eb, es);
      end
      checks++;
      if (a2 !== ea2 || b2 !== eb2 || s2 !== es2) begin
        errors++;
        $display("FAIL random32 cyc %0d: got A=%h B=%h S=%h required %h/%h/%h",
                 n, a2, b2, s2, ea2, eb2, es2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_collision();
    test_hold();
    test_status();
    test_params();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
